// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage -- execute stage of the 32-bit RISC-V 5-stage pipeline.
//
// Computes the RV32I ALU and RV32M MUL* results in one cycle and holds the
// EXE/MEM pipeline register that feeds the memory stage. When the macro
// EXE_DIV_EN is defined, DIV/DIVU/REM/REMU run on a 32-iteration radix-2
// restoring divider controlled by an IDLE/BUSY/DONE FSM. While that divider
// works, stall_EXE holds ID/IF and the EXE/MEM register takes bubbles. When
// EXE_DIV_EN is undefined (the default build), ALUCtrl 14-17 return 0 in one
// cycle and stall_EXE is tied to 0.
//
// Ports
//   clock, reset        rising-edge clock; synchronous active-low reset
//   hit                 global advance; 0 freezes the EXE/MEM register
//   ALUCtrl_ID          operation select (0..17; 18..31 give 0)
//   OpA_ID, OpB_ID      forwarded operands
//   StoreData_ID        rs2 value for stores -> MemWriteData
//   Immediate_ID        sign-extended immediate -> Immediate_EXE
//   *_ID controls       MemWrite, RegWrite, MemtoReg, WriteReg, sw..lbu
//   ALUResult           registered result / memory address
//   *_EXE               registered copies of the ID controls
//   stall_EXE           combinational; 1 means ID/IF must hold
// ---------------------------------------------------------------------------
module exe_stage #(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            hit,
  input  logic [4:0]      ALUCtrl_ID,
  input  logic [XLEN-1:0] OpA_ID,
  input  logic [XLEN-1:0] OpB_ID,
  input  logic [XLEN-1:0] StoreData_ID,
  input  logic [XLEN-1:0] Immediate_ID,
  input  logic            MemWrite_ID,
  input  logic            RegWrite_ID,
  input  logic [1:0]      MemtoReg_ID,
  input  logic [4:0]      WriteReg_ID,
  input  logic            sw_ID,
  input  logic            sh_ID,
  input  logic            sb_ID,
  input  logic            lw_ID,
  input  logic            lh_ID,
  input  logic            lhu_ID,
  input  logic            lb_ID,
  input  logic            lbu_ID,
  output logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] MemWriteData,
  output logic [XLEN-1:0] Immediate_EXE,
  output logic            MemWrite_EXE,
  output logic            RegWrite_EXE,
  output logic [1:0]      MemtoReg_EXE,
  output logic [4:0]      WriteReg_EXE,
  output logic            sw_EXE,
  output logic            sh_EXE,
  output logic            sb_EXE,
  output logic            lw_EXE,
  output logic            lh_EXE,
  output logic            lhu_EXE,
  output logic            lb_EXE,
  output logic            lbu_EXE,
  output logic            stall_EXE
);

  if (XLEN != 32 || DIV_ITERS != XLEN) begin : g_cfg_check
    $error("exe_stage supports only XLEN=32 with DIV_ITERS=XLEN");
  end

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  // -------------------------------------------------------------------------
  // Single-cycle ALU / multiplier
  // -------------------------------------------------------------------------
  logic [4:0]        shamt;
  logic              mul_a_signed;
  logic              mul_b_signed;
  logic [2*XLEN-1:0] mul_a_ext;
  logic [2*XLEN-1:0] mul_b_ext;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   alu_result;

  assign shamt        = OpB_ID[4:0];
  assign mul_a_signed = (ALUCtrl_ID == OP_MULH) || (ALUCtrl_ID == OP_MULHSU);
  assign mul_b_signed = (ALUCtrl_ID == OP_MULH);

  // Each operand is sign- or zero-extended to 64 bits according to the flavour,
  // so a single product taken modulo 2^64 yields the right high half for
  // MULH/MULHSU/MULHU and the (flavour-independent) low half for MUL.
  assign mul_a_ext = {{XLEN{mul_a_signed & OpA_ID[XLEN-1]}}, OpA_ID};
  assign mul_b_ext = {{XLEN{mul_b_signed & OpB_ID[XLEN-1]}}, OpB_ID};
  assign mul_prod  = mul_a_ext * mul_b_ext;

`ifdef EXE_DIV_EN
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [4:0]      CNT_LOAD = 5'(DIV_ITERS - 1);

  logic is_div_op;
  logic is_signed_div;
  logic is_rem_op;
  logic div_by_zero;
  logic div_ovf;
  logic div_req;

  assign is_div_op     = (ALUCtrl_ID == OP_DIV) || (ALUCtrl_ID == OP_DIVU) ||
                         (ALUCtrl_ID == OP_REM) || (ALUCtrl_ID == OP_REMU);
  assign is_signed_div = (ALUCtrl_ID == OP_DIV) || (ALUCtrl_ID == OP_REM);
  assign is_rem_op     = (ALUCtrl_ID == OP_REM) || (ALUCtrl_ID == OP_REMU);
  assign div_by_zero   = (OpB_ID == '0);
  assign div_ovf       = is_signed_div && (OpA_ID == INT_MIN) && (OpB_ID == '1);
  // Only divides without a closed-form answer need the iterative engine.
  assign div_req       = is_div_op && !div_by_zero && !div_ovf;
`endif

  always_comb begin
    // NOTE: assigning a default before the case means every path writes
    // alu_result, so this block cannot infer a latch.
    alu_result = '0;
    unique case (ALUCtrl_ID)
      OP_ADD:    alu_result = OpA_ID + OpB_ID;
      OP_SUB:    alu_result = OpA_ID - OpB_ID;
      OP_SLL:    alu_result = OpA_ID << shamt;
      OP_SLT:    alu_result = {{(XLEN-1){1'b0}}, $signed(OpA_ID) < $signed(OpB_ID)};
      OP_SLTU:   alu_result = {{(XLEN-1){1'b0}}, OpA_ID < OpB_ID};
      OP_XOR:    alu_result = OpA_ID ^ OpB_ID;
      OP_SRL:    alu_result = OpA_ID >> shamt;
      OP_SRA:    alu_result = $unsigned($signed(OpA_ID) >>> shamt);
      OP_OR:     alu_result = OpA_ID | OpB_ID;
      OP_AND:    alu_result = OpA_ID & OpB_ID;
      OP_MUL:    alu_result = mul_prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  alu_result = mul_prod[2*XLEN-1:XLEN];
`ifdef EXE_DIV_EN
      // Non-special divides get their value from the divider in DONE, so
      // only the two closed-form cases matter here.
      OP_DIV,
      OP_DIVU:   alu_result = div_by_zero ? '1 : (div_ovf ? INT_MIN : '0);
      OP_REM,
      OP_REMU:   alu_result = div_by_zero ? OpA_ID : '0;
`endif
      default:   alu_result = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Iterative divider
  // -------------------------------------------------------------------------
  logic            stall_int;
  logic [XLEN-1:0] ex_result;

`ifdef EXE_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

  div_state_e      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic [XLEN-1:0] rem_q, rem_d;     // partial remainder
  logic [XLEN-1:0] dvs_q, dvs_d;     // |divisor|
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            rem_op_q, rem_op_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   shifted;
  logic            trial_ge;
  logic [XLEN-1:0] trial;
  logic [XLEN-1:0] quo_fixed, rem_fixed, div_result;
  logic            div_done;

  assign a_neg = is_signed_div & OpA_ID[XLEN-1];
  assign b_neg = is_signed_div & OpB_ID[XLEN-1];
  assign abs_a = a_neg ? -OpA_ID : OpA_ID;
  assign abs_b = b_neg ? -OpB_ID : OpB_ID;

  // The shifted remainder can reach 33 bits for large unsigned divisors, but
  // whenever the trial succeeds the true difference is below the divisor, so
  // a 32-bit subtraction is exact.
  assign shifted  = {rem_q, quo_q[XLEN-1]};
  assign trial_ge = (shifted >= {1'b0, dvs_q});
  assign trial    = shifted[XLEN-1:0] - dvs_q;

  assign quo_fixed  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
  assign rem_fixed  = sign_a_q ? -rem_q : rem_q;
  assign div_result = rem_op_q ? rem_fixed : quo_fixed;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (div_req) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  if (hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    stall_int = 1'b0;
    div_done  = 1'b0;
    unique case (state_q)
      S_IDLE:  stall_int = div_req;
      S_BUSY:  stall_int = 1'b1;
      S_DONE:  div_done  = 1'b1;
      default: ;
    endcase
  end

  // Divider datapath.
  always_comb begin
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    rem_op_d = rem_op_q;
    unique case (state_q)
      S_IDLE: begin
        if (div_req) begin
          quo_d    = abs_a;
          rem_d    = '0;
          dvs_d    = abs_b;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          rem_op_d = is_rem_op;
          cnt_d    = CNT_LOAD;
        end
      end
      S_BUSY: begin
        if (trial_ge) begin
          rem_d = trial;
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q != '0) cnt_d = cnt_q - 5'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_op_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      rem_op_q <= rem_op_d;
    end
  end

  assign ex_result = div_done ? div_result : alu_result;
`else
  assign stall_int = 1'b0;
  assign ex_result = alu_result;
`endif

  assign stall_EXE = stall_int;

  // -------------------------------------------------------------------------
  // EXE/MEM pipeline register
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic            mem_write_q, mem_write_d;
  logic            reg_write_q, reg_write_d;
  logic [1:0]      mem_to_reg_q, mem_to_reg_d;
  logic [4:0]      write_reg_q, write_reg_d;
  logic [7:0]      mem_flags_q, mem_flags_d;   // {sw,sh,sb,lw,lh,lhu,lb,lbu}

  always_comb begin
    alu_result_d = alu_result_q;
    mem_wdata_d  = mem_wdata_q;
    imm_d        = imm_q;
    mem_write_d  = mem_write_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    write_reg_d  = write_reg_q;
    mem_flags_d  = mem_flags_q;
    if (hit) begin
      if (stall_int) begin
        // Bubble: kill every side effect, leave the data fields alone.
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        mem_flags_d = '0;
      end else begin
        alu_result_d = ex_result;
        mem_wdata_d  = StoreData_ID;
        imm_d        = Immediate_ID;
        mem_write_d  = MemWrite_ID;
        reg_write_d  = RegWrite_ID;
        mem_to_reg_d = MemtoReg_ID;
        write_reg_d  = WriteReg_ID;
        mem_flags_d  = {sw_ID, sh_ID, sb_ID, lw_ID, lh_ID, lhu_ID, lb_ID, lbu_ID};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its _d, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      alu_result_q <= '0;
      mem_wdata_q  <= '0;
      imm_q        <= '0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= '0;
      write_reg_q  <= '0;
      mem_flags_q  <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      mem_wdata_q  <= mem_wdata_d;
      imm_q        <= imm_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      write_reg_q  <= write_reg_d;
      mem_flags_q  <= mem_flags_d;
    end
  end

  assign ALUResult     = alu_result_q;
  assign MemWriteData  = mem_wdata_q;
  assign Immediate_EXE = imm_q;
  assign MemWrite_EXE  = mem_write_q;
  assign RegWrite_EXE  = reg_write_q;
  assign MemtoReg_EXE  = mem_to_reg_q;
  assign WriteReg_EXE  = write_reg_q;
  assign {sw_EXE, sh_EXE, sb_EXE, lw_EXE, lh_EXE, lhu_EXE, lb_EXE, lbu_EXE} = mem_flags_q;

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage. Expected EXE/MEM contents are pushed to a queue as
// each instruction is driven and popped when the register is expected to load.
module tb_exe_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        hit;
  logic [4:0]  ALUCtrl_ID;
  logic [31:0] OpA_ID, OpB_ID, StoreData_ID, Immediate_ID;
  logic        MemWrite_ID, RegWrite_ID;
  logic [1:0]  MemtoReg_ID;
  logic [4:0]  WriteReg_ID;
  logic        sw_ID, sh_ID, sb_ID, lw_ID, lh_ID, lhu_ID, lb_ID, lbu_ID;
  logic [31:0] ALUResult, MemWriteData, Immediate_EXE;
  logic        MemWrite_EXE, RegWrite_EXE;
  logic [1:0]  MemtoReg_EXE;
  logic [4:0]  WriteReg_EXE;
  logic        sw_EXE, sh_EXE, sb_EXE, lw_EXE, lh_EXE, lhu_EXE, lb_EXE, lbu_EXE;
  logic        stall_EXE;

  always #5 clock = ~clock;

  exe_stage dut (
    .clock(clock), .reset(reset), .hit(hit), .ALUCtrl_ID(ALUCtrl_ID),
    .OpA_ID(OpA_ID), .OpB_ID(OpB_ID), .StoreData_ID(StoreData_ID),
    .Immediate_ID(Immediate_ID), .MemWrite_ID(MemWrite_ID), .RegWrite_ID(RegWrite_ID),
    .MemtoReg_ID(MemtoReg_ID), .WriteReg_ID(WriteReg_ID),
    .sw_ID(sw_ID), .sh_ID(sh_ID), .sb_ID(sb_ID), .lw_ID(lw_ID),
    .lh_ID(lh_ID), .lhu_ID(lhu_ID), .lb_ID(lb_ID), .lbu_ID(lbu_ID),
    .ALUResult(ALUResult), .MemWriteData(MemWriteData), .Immediate_EXE(Immediate_EXE),
    .MemWrite_EXE(MemWrite_EXE), .RegWrite_EXE(RegWrite_EXE),
    .MemtoReg_EXE(MemtoReg_EXE), .WriteReg_EXE(WriteReg_EXE),
    .sw_EXE(sw_EXE), .sh_EXE(sh_EXE), .sb_EXE(sb_EXE), .lw_EXE(lw_EXE),
    .lh_EXE(lh_EXE), .lhu_EXE(lhu_EXE), .lb_EXE(lb_EXE), .lbu_EXE(lbu_EXE),
    .stall_EXE(stall_EXE)
  );

`ifdef EXE_DIV_EN
  localparam int DIV_STALL = 33;
`else
  localparam int DIV_STALL = 0;
`endif

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] wdata;
    logic [31:0] imm;
    logic        mw;
    logic        rw;
    logic [1:0]  m2r;
    logic [4:0]  wr;
    logic [7:0]  flags;
  } exe_t;

  exe_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model of the registered result.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, ub_s, p;
    longint unsigned ua, ub, pu;
    logic [63:0]     pv;
    sa = $signed(a);
    sb = $signed(b);
    ub_s = b;
    ua = a;
    ub = b;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  begin p = sa >>> b[4:0]; pv = p; return pv[31:0]; end
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: begin p = sa * sb;   pv = p;  return pv[31:0];  end
      5'd11: begin p = sa * sb;   pv = p;  return pv[63:32]; end
      5'd12: begin p = sa * ub_s; pv = p;  return pv[63:32]; end
      5'd13: begin pu = ua * ub;  pv = pu; return pv[63:32]; end
`ifdef EXE_DIV_EN
      5'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; pv = p; return pv[31:0];
      end
      5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; pv = p; return pv[31:0];
      end
      5'd17: return (b == 0) ? a : a % b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_stalls(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    logic is_div, special;
    is_div  = (op >= 5'd14) && (op <= 5'd17);
    special = (b == 0) ||
              ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (is_div && !special) ? DIV_STALL : 0;
  endfunction

  function automatic exe_t sample();
    exe_t s;
    s.result = ALUResult;
    s.wdata  = MemWriteData;
    s.imm    = Immediate_EXE;
    s.mw     = MemWrite_EXE;
    s.rw     = RegWrite_EXE;
    s.m2r    = MemtoReg_EXE;
    s.wr     = WriteReg_EXE;
    s.flags  = {sw_EXE, sh_EXE, sb_EXE, lw_EXE, lh_EXE, lhu_EXE, lb_EXE, lbu_EXE};
    return s;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive one instruction on the ID side with random side-band fields and
  // queue the EXE/MEM contents it should produce.
  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exe_t e;
    ALUCtrl_ID   = op;
    OpA_ID       = a;
    OpB_ID       = b;
    StoreData_ID = $urandom;
    Immediate_ID = $urandom;
    MemWrite_ID  = 1'($urandom);
    RegWrite_ID  = 1'($urandom);
    MemtoReg_ID  = 2'($urandom);
    WriteReg_ID  = 5'($urandom);
    {sw_ID, sh_ID, sb_ID, lw_ID, lh_ID, lhu_ID, lb_ID, lbu_ID} = 8'($urandom);
    e.result = model(op, a, b);
    e.wdata  = StoreData_ID;
    e.imm    = Immediate_ID;
    e.mw     = MemWrite_ID;
    e.rw     = RegWrite_ID;
    e.m2r    = MemtoReg_ID;
    e.wr     = WriteReg_ID;
    e.flags  = {sw_ID, sh_ID, sb_ID, lw_ID, lh_ID, lhu_ID, lb_ID, lbu_ID};
    exp_q.push_back(e);
    #1;
  endtask

  // Step while stall_EXE is high (bounded), counting stalled cycles and the
  // cycles whose EXE/MEM contents were not a proper bubble.
  task automatic wait_div(output int stalls, output int bad);
    exe_t prev, obs, bub;
    stalls = 0;
    bad    = 0;
    while (stall_EXE === 1'b1 && stalls < 100) begin
      prev = sample();
      step();
      stalls++;
      bub       = prev;
      bub.rw    = 1'b0;
      bub.mw    = 1'b0;
      bub.flags = '0;
      obs       = sample();
      if (obs !== bub) bad++;
    end
  endtask

  task automatic test_reset();
    exe_t obs;
    reset = 1'b0;
    hit   = 1'b1;
    drive(5'd0, 32'h1234_5678, 32'h1111_1111);
    exp_q.delete();
    step();
    step();
    obs = sample();
    n_total++;
    if (obs !== '0) $display("FAIL reset_outputs: got %h want 0", obs);
    else n_pass++;
    n_total++;
    if (stall_EXE !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_EXE);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_alu();
    exe_t       e, obs;
    logic       s;
    logic [31:0] av[2] = '{32'hF123_4567, 32'h7FFF_FFFF};
    logic [31:0] bv[2] = '{32'h8765_4325, 32'hFFFF_FFFF};
    drive(5'd0, 32'd5, 32'hFFFF_FFFD);
    s = stall_EXE;
    step();
    obs = sample();
    e = exp_q.pop_front();
    n_total++;
    if (ALUResult !== 32'd2 || s !== 1'b0)
      $display("FAIL add_5_m3: got %h stall %b want 00000002 stall 0", ALUResult, s);
    else n_pass++;
    n_total++;
    if (obs !== e) $display("FAIL add_fields: got %h want %h", obs, e);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      for (int op = 1; op < 32; op++) begin
        if (op >= 14 && op <= 17) continue;
        drive(5'(op), av[k], bv[k]);
        s = stall_EXE;
        step();
        obs = sample();
        e = exp_q.pop_front();
        n_total++;
        if ({obs, s} !== {e, 1'b0})
          $display("FAIL alu_op%0d: got %h stall %b want %h stall 0", op, obs.result, s, e.result);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exe_t        e, obs;
    logic [4:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 5'($urandom_range(0, 27));
      if (op >= 5'd14) op = op + 5'd4;   // skip the divide codes
      a = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      b = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      drive(op, a, b);
      step();
      obs = sample();
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL b2b_%0d_op%0d: got %h want %h", i, op, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_div_special();
    exe_t        e, obs;
    logic        s;
    logic [4:0]  ops[6] = '{5'd14, 5'd16, 5'd14, 5'd16, 5'd15, 5'd17};
    logic [31:0] as[6]  = '{32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9, 32'd5, 32'hDEAD_BEEF};
    logic [31:0] bs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], as[i], bs[i]);
      s = stall_EXE;
      step();
      obs = sample();
      e = exp_q.pop_front();
      n_total++;
      if ({obs, s} !== {e, 1'b0})
        $display("FAIL div_special_%0d: got %h stall %b want %h stall 0", i, obs.result, s, e.result);
      else n_pass++;
    end
  endtask

  task automatic test_div();
    exe_t        e, obs;
    int          st, bad;
    logic [4:0]  ops[7] = '{5'd15, 5'd17, 5'd14, 5'd16, 5'd14, 5'd17, 5'd16};
    logic [31:0] as[7]  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs[7]  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FF00, 32'd3, 32'd3};
    for (int i = 0; i < 7; i++) begin
      drive(ops[i], as[i], bs[i]);
      wait_div(st, bad);
      n_total++;
      if (st != exp_stalls(ops[i], as[i], bs[i]))
        $display("FAIL div_stall_%0d: got %0d cycles want %0d", i, st, exp_stalls(ops[i], as[i], bs[i]));
      else n_pass++;
      n_total++;
      if (bad != 0) $display("FAIL div_bubble_%0d: got %0d bad bubbles want 0", i, bad);
      else n_pass++;
      step();
      obs = sample();
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL div_result_%0d: got %h want %h", i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    exe_t e, obs, held;
    int   st, bad;
    drive(5'd0, 32'd1, 32'd2);
    step();
    held = exp_q.pop_front();
    hit = 1'b0;
    drive(5'd0, 32'd10, 32'd20);
    for (int i = 0; i < 3; i++) begin
      step();
      obs = sample();
      n_total++;
      if (obs !== held) $display("FAIL hold_alu_%0d: got %h want %h", i, obs, held);
      else n_pass++;
    end
    hit = 1'b1;
    step();
    obs = sample();
    e = exp_q.pop_front();
    n_total++;
    if (obs !== e) $display("FAIL hold_release: got %h want %h", obs, e);
    else n_pass++;

    drive(5'd15, 32'd1000, 32'd9);
    wait_div(st, bad);
    n_total++;
    if (st != DIV_STALL || bad != 0)
      $display("FAIL hold_div_stall: got %0d cycles %0d bad want %0d cycles 0 bad", st, bad, DIV_STALL);
    else n_pass++;
    held = sample();
    hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = sample();
      n_total++;
      if ({obs, stall_EXE} !== {held, 1'b0})
        $display("FAIL hold_done_%0d: got %h stall %b want %h stall 0", i, obs, stall_EXE, held);
      else n_pass++;
    end
    hit = 1'b1;
    step();
    obs = sample();
    e = exp_q.pop_front();
    n_total++;
    if (obs !== e) $display("FAIL hold_done_release: got %h want %h", obs, e);
    else n_pass++;
  endtask

  task automatic test_reset_mid_div();
    exe_t e, obs;
    logic s;
    drive(5'd15, 32'hFFFF_FFF0, 32'd3);
    repeat (22) step();   // one IDLE cycle plus 21 BUSY cycles: counter at 10
    exp_q.delete();
    reset      = 1'b0;
    ALUCtrl_ID = 5'd0;
    step();
    obs = sample();
    n_total++;
    if ({obs, stall_EXE} !== {$bits(exe_t)'(0), 1'b0})
      $display("FAIL reset_mid_div: got %h stall %b want 0 stall 0", obs, stall_EXE);
    else n_pass++;
    reset = 1'b1;
    drive(5'd0, 32'd7, 32'd8);
    s = stall_EXE;
    step();
    obs = sample();
    e = exp_q.pop_front();
    n_total++;
    if ({obs, s} !== {e, 1'b0}) $display("FAIL after_reset_add: got %h stall %b want %h", obs, s, e);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    hit   = 1'b1;
    test_reset();
    test_alu();
    test_back_to_back();
    test_div_special();
    test_div();
    test_hold();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
